alu_seq: RTL and testbench

Parametrised sequential ALU; next generation of the 8-bit combinational ALU. WIDTH-bit operands, 4-bit instruction, and flags. An iterative shift-add multiplier covers MUL/MULH. A valid/ready handshake is used on both the operation input and the result output. It sits between an operand source, such as a register file or test sequencer, and a result consumer that may apply backpressure.

---
 rtl/alu_seq_pkg.sv | 38 +++
 rtl/alu_mul_iter.sv | 56 +++++
 rtl/alu_seq.sv | 163 ++++++++++++++++
 tb/tb_alu_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM encodings for the sequential ALU.
package alu_seq_pkg;

    localparam int unsigned OP_W = 4;

    // Instruction encodings; all 16 values are defined.
    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_SLL  = 4'd6,
        OP_SRL  = 4'd7,
        OP_SRA  = 4'd8,
        OP_ROL  = 4'd9,
        OP_ROR  = 4'd10,
        OP_SLT  = 4'd11,
        OP_SLTU = 4'd12,
        OP_MUL  = 4'd13,
        OP_MULH = 4'd14,
        OP_PASS = 4'd15
    } opcode_e;

    // Control FSM states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    // True for opcodes serviced by the iterative multiplier.
    function automatic logic is_mul_op(input opcode_e op);
        return (op == OP_MUL) || (op == OP_MULH);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0]   a_q;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     sum;

    // Upper half plus multiplicand when the current multiplier bit is set.
    always_comb begin
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? a_q : {WIDTH{1'b0}})};
    end

    // Accumulator holds {partial sum, remaining multiplier bits}; shifts right each step.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q  <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_q  <= a;
                acc  <= {{WIDTH{1'b0}}, b};
                cnt  <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                acc <= {sum, acc[WIDTH-1:1]};
                cnt <= cnt + CW'(1);
                if (cnt == LAST) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign product = acc;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes and an iterative multiplier.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        instruction,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  F,
    output logic              carry,
    output logic              zero
);

    state_e               state;
    state_e               state_next;
    opcode_e              op_in;
    logic                 accept;
    logic                 load_alu;
    logic                 load_mul;
    logic                 mul_start;
    logic                 mul_high;
    logic                 mul_busy;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;
    logic [WIDTH-1:0]     mul_sel;
    logic [WIDTH:0]       alu_res;

    // Single-cycle ops; returns {carry, result}.
    function automatic logic [WIDTH:0] alu_eval(
        input opcode_e          op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [SHW-1:0]     s;
        logic [WIDTH:0]     wide;
        logic [2*WIDTH-1:0] dbl;
        logic [WIDTH-1:0]   f;
        logic               c;
        s    = b[SHW-1:0];
        wide = '0;
        dbl  = '0;
        f    = '0;
        c    = 1'b0;
        case (op)
            OP_ADD:  {c, f} = {1'b0, a} + {1'b0, b};
            OP_SUB:  begin f = a - b; c = (a >= b); end
            OP_AND:  f = a & b;
            OP_OR:   f = a | b;
            OP_XOR:  f = a ^ b;
            OP_NOT:  f = ~a;
            // Extra bit beside the operand catches the last bit shifted out.
            OP_SLL:  begin wide = {1'b0, a} << s; {c, f} = wide; end
            OP_SRL:  begin wide = {a, 1'b0} >> s; {f, c} = wide; end
            OP_SRA:  begin wide = $unsigned($signed({a, 1'b0}) >>> s); {f, c} = wide; end
            // Doubled operand turns a rotate into a plain shift.
            OP_ROL:  begin dbl = {a, a} << s; f = dbl[2*WIDTH-1:WIDTH]; end
            OP_ROR:  begin dbl = {a, a} >> s; f = dbl[WIDTH-1:0]; end
            OP_SLT:  f = WIDTH'($signed(a) < $signed(b));
            OP_SLTU: f = WIDTH'(a < b);
            OP_PASS: f = b;
            default: f = '0;
        endcase
        return {c, f};
    endfunction

    assign op_in    = opcode_e'(instruction);
    assign alu_res  = alu_eval(op_in, A, B);
    assign mul_sel  = mul_high ? mul_product[2*WIDTH-1:WIDTH] : mul_product[WIDTH-1:0];
    assign in_ready = ~rst & ~mul_busy &
                      ((state == S_IDLE) | ((state == S_HOLD) & out_ready));
    assign accept   = in_valid & in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state and load strobes; HOLD with out_ready behaves like IDLE.
    always_comb begin
        state_next = state;
        load_alu   = 1'b0;
        load_mul   = 1'b0;
        mul_start  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_mul_op(op_in)) begin
                        mul_start  = 1'b1;
                        state_next = S_MUL;
                    end else begin
                        load_alu   = 1'b1;
                        state_next = S_HOLD;
                    end
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    load_mul   = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                    if (accept) begin
                        if (is_mul_op(op_in)) begin
                            mul_start  = 1'b1;
                            state_next = S_MUL;
                        end else begin
                            load_alu   = 1'b1;
                            state_next = S_HOLD;
                        end
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Result registers; out_valid tracks entry into HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            F         <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
            mul_high  <= 1'b0;
        end else begin
            out_valid <= (state_next == S_HOLD);
            if (mul_start) mul_high <= (op_in == OP_MULH);
            if (load_alu) begin
                F     <= alu_res[WIDTH-1:0];
                carry <= alu_res[WIDTH];
                zero  <= (alu_res[WIDTH-1:0] == '0);
            end else if (load_mul) begin
                F     <= mul_sel;
                carry <= 1'b0;
                zero  <= (mul_sel == '0);
            end
        end
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq against a cycle-level behavioural model.
module tb_alu_seq;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    localparam logic [3:0] ADD = 4'd0,  SUB = 4'd1,  XOR = 4'd4,  SLL = 4'd6,
                           SRL = 4'd7,  SRA = 4'd8,  ROL = 4'd9,  SLT = 4'd11,
                           SLTU = 4'd12, MUL = 4'd13, MULH = 4'd14, PASS = 4'd15;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   instruction = 4'd0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] F;
    logic         carry;
    logic         zero;

    int total = 0;
    int bad   = 0;

    // Model state: presented result, pending multiply, reset-cleared flag.
    bit m_ov    = 1'b0;
    bit m_clean = 1'b0;
    bit m_pend  = 1'b0;
    int m_cnt   = 0;
    int m_f = 0, m_c = 0, m_z = 0;
    int p_f = 0, p_c = 0;
    logic last_rdy;

    alu_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .A           (A),
        .B           (B),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .F           (F),
        .carry       (carry),
        .zero        (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference result from plain integer arithmetic.
    function automatic void ref_op(input int ins, input int a, input int b,
                                   output int f, output int c);
        int s, sa, sb;
        s  = b % W;
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        f  = 0;
        c  = 0;
        case (ins)
            0:  begin f = (a + b) & MASK; c = ((a + b) >> W) & 1; end
            1:  begin f = (a - b) & MASK; c = (a >= b) ? 1 : 0; end
            2:  f = a & b;
            3:  f = a | b;
            4:  f = a ^ b;
            5:  f = (~a) & MASK;
            6:  begin f = (a << s) & MASK; c = (s != 0) ? (a >> (W - s)) & 1 : 0; end
            7:  begin f = a >> s; c = (s != 0) ? (a >> (s - 1)) & 1 : 0; end
            8:  begin f = (sa >>> s) & MASK; c = (s != 0) ? (a >> (s - 1)) & 1 : 0; end
            9:  f = ((a << s) | (a >> (W - s))) & MASK;
            10: f = ((a >> s) | (a << (W - s))) & MASK;
            11: f = (sa < sb) ? 1 : 0;
            12: f = (a < b) ? 1 : 0;
            13: f = (a * b) & MASK;
            14: f = ((a * b) >> W) & MASK;
            default: f = b;
        endcase
    endfunction

    // One clock cycle: drive, check in_ready, advance model, check outputs.
    task automatic step(input logic r, input logic iv, input logic [3:0] ins,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy);
        int f, c;
        bit m_rdy;
        rst = r; in_valid = iv; instruction = ins; A = a; B = b; out_ready = ordy;
        #1;
        m_rdy = !r && !m_pend && (!m_ov || ordy);
        chk("in_ready", 32'(in_ready), 32'(m_rdy));
        last_rdy = in_ready;
        if (r) begin
            m_ov = 0; m_pend = 0; m_cnt = 0; m_clean = 1;
            m_f = 0; m_c = 0; m_z = 0;
        end else begin
            if (m_ov && ordy) m_ov = 0;
            if (m_pend) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_pend = 0; m_ov = 1;
                    m_f = p_f; m_c = p_c; m_z = (p_f == 0) ? 1 : 0;
                end
            end
            if (iv && m_rdy) begin
                ref_op(int'(ins), int'(a), int'(b), f, c);
                m_clean = 0;
                if (ins == MUL || ins == MULH) begin
                    m_pend = 1; m_cnt = W + 1; p_f = f; p_c = c;
                end else begin
                    m_ov = 1; m_f = f; m_c = c; m_z = (f == 0) ? 1 : 0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov || m_clean) begin
            chk("F", 32'(F), 32'(m_f));
            chk("carry", 32'(carry), 32'(m_c));
            chk("zero", 32'(zero), 32'(m_z));
        end
    endtask

    task automatic op(input logic [3:0] ins, input logic [W-1:0] a, input logic [W-1:0] b);
        step(1'b0, 1'b1, ins, a, b, 1'b1);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 4'd0, '0, '0, ordy);
    endtask

    initial begin
        @(negedge clk);
        // Reset
        step(1'b1, 1'b0, 4'd0, '0, '0, 1'b0);
        step(1'b1, 1'b0, 4'd0, '0, '0, 1'b0);
        chk("rst_ready", 32'(last_rdy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_F", 32'(F), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        idle(1'b1);
        chk("ready_after_rst", 32'(last_rdy), 32'd1);

        // Arithmetic
        op(ADD, 8'hFF, 8'h01);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_F", 32'(F), 32'h00);
        chk("add_carry", 32'(carry), 32'd1);
        chk("add_zero", 32'(zero), 32'd1);
        op(SUB, 8'h05, 8'h07);
        chk("sub_F", 32'(F), 32'hFE);
        chk("sub_carry", 32'(carry), 32'd0);

        // Multiply latency and blocked input
        op(MUL, 8'hFF, 8'hFF);
        for (int k = 1; k <= W + 1; k++) begin
            step(1'b0, 1'b1, PASS, 8'($urandom), 8'($urandom), 1'b1);
            chk("mul_ready_low", 32'(last_rdy), 32'd0);
            if (k == W) chk("mul_not_early", 32'(out_valid), 32'd0);
        end
        chk("mul_valid", 32'(out_valid), 32'd1);
        chk("mul_F", 32'(F), 32'h01);
        op(MULH, 8'hFF, 8'hFF);
        for (int k = 1; k <= W + 1; k++) idle(1'b1);
        chk("mulh_F", 32'(F), 32'hFE);

        // Shifts and compares
        op(SRL, 8'h81, 8'h01);
        chk("srl_F", 32'(F), 32'h40);
        chk("srl_carry", 32'(carry), 32'd1);
        op(SRA, 8'h80, 8'h03);
        chk("sra_F", 32'(F), 32'hF0);
        chk("sra_carry", 32'(carry), 32'd0);
        op(ROL, 8'h81, 8'h01);
        chk("rol_F", 32'(F), 32'h03);
        op(SLL, 8'h5A, 8'h08);
        chk("sll0_F", 32'(F), 32'h5A);
        chk("sll0_carry", 32'(carry), 32'd0);
        op(SLT, 8'h80, 8'h01);
        chk("slt_F", 32'(F), 32'h01);
        op(SLTU, 8'h80, 8'h01);
        chk("sltu_F", 32'(F), 32'h00);
        chk("sltu_zero", 32'(zero), 32'd1);

        // Backpressure then simultaneous transfer and accept
        op(XOR, 8'h3C, 8'h0F);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, ADD, 8'h01, 8'h02, 1'b0);
            chk("bp_ready_low", 32'(last_rdy), 32'd0);
            chk("bp_F", 32'(F), 32'h33);
        end
        step(1'b0, 1'b1, ADD, 8'h01, 8'h02, 1'b1);
        chk("bp_accept", 32'(last_rdy), 32'd1);
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_F", 32'(F), 32'h03);

        // Reset during a multiply
        op(MUL, 8'h12, 8'h34);
        for (int k = 0; k < 3; k++) idle(1'b1);
        step(1'b1, 1'b0, 4'd0, '0, '0, 1'b1);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_F", 32'(F), 32'h00);
        idle(1'b1);
        chk("abort_ready", 32'(last_rdy), 32'd1);
        for (int k = 0; k < 12; k++) idle(1'b1);
        chk("abort_no_result", 32'(out_valid), 32'd0);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            step(1'b0 | ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) < 7),
                 4'($urandom_range(0, 15)),
                 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 9) < 7));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
